hskbus_uart_tx: RTL

- 8N1 UART transmitter. Drives the TURFIO's own response bytes onto the housekeeping bus return line at 500 kbps from the 80 MHz init clock.
- Receives bytes on a valid/ready byte stream, with a last marker per packet.
- Before the first byte of a packet, waits until the monitored bus line has been quiet for a guard time. This prevents it from talking over SURF or hski2c responders.
- Counts transmitted bytes. This counter mirrors the bus-side received-byte counter used for debugging.

---
 rtl/hskbus_uart_tx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hskbus_uart_tx.sv
// 8N1 transmitter for the housekeeping bus return line. A packet's first byte is held off until the bus is quiet; tx_o goes low the cycle after accept.
// Each byte takes 10*CLKS_PER_BIT clocks. s_tready_o is low while a byte is on the wire. Optional HSKBUS_TX_COLLISION_EN adds mid-bit collision abort and packet drain.
module hskbus_uart_tx #(
  parameter int CLKS_PER_BIT = 160,
  parameter int IDLE_BITS    = 10
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] s_tdata_i,
  input  logic       s_tvalid_i,
  input  logic       s_tlast_i,
  output logic       s_tready_o,
  input  logic       bus_rx_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic [7:0] tx_bytes_o,
  output logic       collision_o
);
  localparam int QUIET_MAX = IDLE_BITS * CLKS_PER_BIT;
  localparam int QW = $clog2(QUIET_MAX + 1);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [QW-1:0] QUIET_SAT = QW'(QUIET_MAX);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

`ifdef HSKBUS_TX_COLLISION_EN
  // Synchronized line lags the wire by two clocks, so look two clocks past mid-bit.
  localparam logic [CW-1:0] SAMPLE_AT = CW'((CLKS_PER_BIT / 2 + 2 < CLKS_PER_BIT) ?
                                            CLKS_PER_BIT / 2 + 2 : CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DRAIN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic            in_pkt_q, in_pkt_d;
  logic [7:0]      data_q, data_d;
  logic [2:0]      bit_q, bit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tx_q, tx_d;
  logic [7:0]      bytes_q, bytes_d;
  logic            rx_s1_q, rx_s2_q;
  logic [QW-1:0]   quiet_q, quiet_d;
  logic            quiet_ok;
  logic            bit_end;
  logic            accept;

  assign quiet_ok   = (quiet_q == QUIET_SAT);
  assign bit_end    = (cnt_q == BIT_LAST);
  assign tx_o       = tx_q;
  assign tx_bytes_o = bytes_q;
  assign busy_o     = in_pkt_q || (state_q != S_IDLE);

`ifdef HSKBUS_TX_COLLISION_EN
  logic coll_q, coll_d;
  assign collision_o = coll_q;
`else
  assign collision_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    in_pkt_d   = in_pkt_q;
    data_d     = data_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    bytes_d    = bytes_q;
    s_tready_o = 1'b0;
    accept     = 1'b0;
    quiet_d    = !rx_s2_q ? '0 : (quiet_ok ? quiet_q : quiet_q + 1'b1);
`ifdef HSKBUS_TX_COLLISION_EN
    coll_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        s_tready_o = in_pkt_q || quiet_ok;
        accept     = s_tvalid_i && s_tready_o;
        if (accept) begin
          data_d   = s_tdata_i;
          in_pkt_d = !s_tlast_i;
          cnt_d    = '0;
          tx_d     = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          tx_d    = data_q[0];
          data_d  = {1'b0, data_q[7:1]};
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            tx_d   = data_q[0];
            data_d = {1'b0, data_q[7:1]};
            bit_d  = bit_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          bytes_d = bytes_q + 8'd1;
          state_d = S_IDLE;
        end
      end
`ifdef HSKBUS_TX_COLLISION_EN
      S_DRAIN: begin
        s_tready_o = 1'b1;
        accept     = s_tvalid_i;
        if (accept && s_tlast_i) begin
          in_pkt_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef HSKBUS_TX_COLLISION_EN
    // Someone else pulled the line low under our bit: back off and discard the rest of the packet.
    if ((state_q == S_START || state_q == S_DATA || state_q == S_STOP) &&
        cnt_q == SAMPLE_AT && !rx_s2_q) begin
      coll_d  = 1'b1;
      tx_d    = 1'b1;
      cnt_d   = '0;
      bytes_d = bytes_q;
      state_d = in_pkt_q ? S_DRAIN : S_IDLE;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      in_pkt_q <= 1'b0;
      data_q   <= 8'd0;
      bit_q    <= 3'd0;
      cnt_q    <= '0;
      tx_q     <= 1'b1;
      bytes_q  <= 8'd0;
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      quiet_q  <= '0;
`ifdef HSKBUS_TX_COLLISION_EN
      coll_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      in_pkt_q <= in_pkt_d;
      data_q   <= data_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      bytes_q  <= bytes_d;
      rx_s1_q  <= bus_rx_i;
      rx_s2_q  <= rx_s1_q;
      quiet_q  <= quiet_d;
`ifdef HSKBUS_TX_COLLISION_EN
      coll_q   <= coll_d;
`endif
    end
  end
endmodule
